bt656_video_rx: RTL

- Upstream front end of the video processing chain; feeds `student_block`.
- Parses an ITU-R BT.656 byte stream (625-line, interlaced, 27 MHz byte rate, qualified by a clock enable on the 108 MHz system clock).
- Extracts luma and crops each line to 702 samples.
- Produces the framing, strobe, data and address signals that the processing block consumes: `video_frame_valid`, `video_line_valid`, `video_data_valid`, `video_data_in`, `video_address`.

---
 rtl/bt656_pkg.sv | 52 +++++
 rtl/bt656_trs_detect.sv | 90 +++++++++
 rtl/bt656_video_rx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bt656_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bt656_pkg
//  Description : Shared constants for the BT.656 receive path: TRS preamble
//                bytes, XY bit positions, address field widths, default
//                parameter values, TRS detector state encoding and the XY
//                protection-bit check.
//  Revision    : 1.0 - initial release
// ============================================================================
package bt656_pkg;

    // TRS preamble: FF 00 00 followed by the XY byte
    localparam logic [7:0] c_TRS_PRE0 = 8'hFF;
    localparam logic [7:0] c_TRS_PRE1 = 8'h00;
    localparam logic [7:0] c_TRS_PRE2 = 8'h00;

    // XY = {1, F, V, H, P3, P2, P1, P0}
    localparam int c_XY_ONE = 7;
    localparam int c_XY_F   = 6;
    localparam int c_XY_V   = 5;
    localparam int c_XY_H   = 4;
    localparam int c_XY_P3  = 3;
    localparam int c_XY_P2  = 2;
    localparam int c_XY_P1  = 1;
    localparam int c_XY_P0  = 0;

    // video_address = {row, field, col}
    localparam int c_ROW_W  = 9;
    localparam int c_COL_W  = 10;
    localparam int c_ADDR_W = c_ROW_W + 1 + c_COL_W;

    localparam int c_ACTIVE_W_DEF        = 702;
    localparam int c_H_SKIP_DEF          = 9;
    localparam int c_LINES_PER_FIELD_DEF = 288;

    // TRS detector states
    localparam logic [1:0] c_S_DATA = 2'd0;
    localparam logic [1:0] c_S_FF   = 2'd1;
    localparam logic [1:0] c_S_Z1   = 2'd2;
    localparam logic [1:0] c_S_Z2   = 2'd3;

    // True when the XY byte carries a consistent set of protection bits
    function automatic logic xy_ok(input logic [7:0] xy);
        return xy[c_XY_ONE]
            && (xy[c_XY_P3] == (xy[c_XY_V] ^ xy[c_XY_H]))
            && (xy[c_XY_P2] == (xy[c_XY_F] ^ xy[c_XY_H]))
            && (xy[c_XY_P1] == (xy[c_XY_F] ^ xy[c_XY_V]))
            && (xy[c_XY_P0] == (xy[c_XY_F] ^ xy[c_XY_V] ^ xy[c_XY_H]));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bt656_trs_detect.sv
`default_nettype none
// ============================================================================
//  Module      : bt656_trs_detect
//  Description : Recognises the FF 00 00 XY timing reference sequence in a
//                BT.656 byte stream and checks the XY protection bits.
//  Ports       : clk, rst        - system clock, async active-high reset
//                bt_ce, bt_data  - byte strobe and byte
//                trs_valid       - XY byte with good protection (same clk)
//                trs_err         - one-clk pulse after a bad XY byte
//                F, V, H         - XY flags, meaningful with trs_valid
//                trs_byte        - current byte belongs to a TRS (00s, XY)
//  Revision    : 1.0 - initial release
// ============================================================================
module bt656_trs_detect
    import bt656_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_ce,
    input  logic [7:0] bt_data,
    output logic       trs_valid,
    output logic       trs_err,
    output logic       F,
    output logic       V,
    output logic       H,
    output logic       trs_byte
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       w_xy_cycle;
    logic       w_xy_good;

    assign w_xy_cycle = bt_ce && (r_state == c_S_Z2);
    assign w_xy_good  = xy_ok(bt_data);

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        if (bt_ce) begin
            case (r_state)
                c_S_DATA: begin
                    if (bt_data == c_TRS_PRE0) w_state_nxt = c_S_FF;
                end
                c_S_FF: begin
                    if (bt_data == c_TRS_PRE1)      w_state_nxt = c_S_Z1;
                    else if (bt_data == c_TRS_PRE0) w_state_nxt = c_S_FF;
                    else                            w_state_nxt = c_S_DATA;
                end
                c_S_Z1: begin
                    if (bt_data == c_TRS_PRE2)      w_state_nxt = c_S_Z2;
                    else if (bt_data == c_TRS_PRE0) w_state_nxt = c_S_FF;
                    else                            w_state_nxt = c_S_DATA;
                end
                c_S_Z2: begin
                    w_err_nxt   = !w_xy_good;
                    w_state_nxt = (bt_data == c_TRS_PRE0) ? c_S_FF : c_S_DATA;
                end
                default: w_state_nxt = c_S_DATA;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_DATA;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // trs_valid is combinational so the top can react in the clk after XY
    assign trs_valid = w_xy_cycle && w_xy_good;
    assign trs_err   = r_err;
    assign F         = bt_data[c_XY_F];
    assign V         = bt_data[c_XY_V];
    assign H         = bt_data[c_XY_H];

    // The 00 bytes of a preamble land on a luma slot, so they must be masked
    // from the data path; a lone FF inside active video stays data.
    assign trs_byte  = w_xy_cycle
                    || (bt_ce && ((r_state == c_S_FF) || (r_state == c_S_Z1))
                              && (bt_data == c_TRS_PRE1));

endmodule
`default_nettype wire

// File: rtl/bt656_video_rx.sv
`default_nettype none
// ============================================================================
//  Module      : bt656_video_rx
//  Description : BT.656 (625-line) receiver. Syncs to field boundaries,
//                extracts luma, crops each line to ACTIVE_W samples and
//                produces frame/line framing, a sample strobe and address.
//  Ports       : clk, rst           - 108 MHz clock, async active-high reset
//                bt_ce, bt_data     - 27 MHz byte strobe and byte
//                video_frame_valid  - field active region in progress
//                video_line_valid   - line samples in progress
//                video_data_valid   - one-clk strobe per luma sample
//                video_data_out     - luma sample
//                video_address      - {row, field, col}
//                trs_err            - XY protection failure pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module bt656_video_rx
    import bt656_pkg::*;
#(
    parameter int ACTIVE_W        = c_ACTIVE_W_DEF,
    parameter int H_SKIP          = c_H_SKIP_DEF,
    parameter int LINES_PER_FIELD = c_LINES_PER_FIELD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bt_ce,
    input  logic [7:0]          bt_data,
    output logic                video_frame_valid,
    output logic                video_line_valid,
    output logic                video_data_valid,
    output logic [7:0]          video_data_out,
    output logic [c_ADDR_W-1:0] video_address,
    output logic                trs_err
);

    localparam logic [c_COL_W-1:0] c_LX_LO    = c_COL_W'(H_SKIP);
    localparam logic [c_COL_W-1:0] c_LX_HI    = c_COL_W'(H_SKIP + ACTIVE_W);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(ACTIVE_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LIM  = c_ROW_W'(LINES_PER_FIELD);

    logic w_trs_valid, w_f, w_v, w_h, w_trs_byte;

    bt656_trs_detect u_trs (
        .clk       (clk),
        .rst       (rst),
        .bt_ce     (bt_ce),
        .bt_data   (bt_data),
        .trs_valid (w_trs_valid),
        .trs_err   (trs_err),
        .F         (w_f),
        .V         (w_v),
        .H         (w_h),
        .trs_byte  (w_trs_byte)
    );

    logic                r_synced, w_synced_nxt;
    logic                r_prev_v, w_prev_v_nxt;
    logic                r_armed,  w_armed_nxt;   // V=1 seen since last field start
    logic                r_field,  w_field_nxt;
    logic [c_ROW_W-1:0]  r_row,    w_row_nxt;
    logic                r_frame,  w_frame_nxt;
    logic                r_active, w_active_nxt;  // SAV accepted for this line
    logic                r_phase,  w_phase_nxt;   // 1: next data byte is Y
    logic [c_COL_W-1:0]  r_lx,     w_lx_nxt;
    logic                r_lv,     w_lv_nxt;
    logic                r_dv,     w_dv_nxt;
    logic [7:0]          r_dout,   w_dout_nxt;
    logic [c_ADDR_W-1:0] r_addr,   w_addr_nxt;

    logic               w_sync_now;
    logic               w_start;
    logic [c_ROW_W-1:0] w_row_base;

    assign w_sync_now = w_trs_valid && !w_v && r_prev_v;
    assign w_start    = w_trs_valid && !w_v && !w_h && r_armed
                     && (r_synced || w_sync_now);
    assign w_row_base = w_start ? '0 : r_row;

    always_comb begin
        w_synced_nxt = r_synced;
        w_prev_v_nxt = r_prev_v;
        w_armed_nxt  = r_armed;
        w_field_nxt  = r_field;
        w_row_nxt    = r_row;
        w_frame_nxt  = r_frame;
        w_active_nxt = r_active;
        w_phase_nxt  = r_phase;
        w_lx_nxt     = r_lx;
        w_lv_nxt     = r_lv;
        w_dv_nxt     = 1'b0;
        w_dout_nxt   = r_dout;
        w_addr_nxt   = r_addr;

        // Line window closes in the clk after the last column's strobe
        if (r_dv && (r_addr[c_COL_W-1:0] == c_COL_LAST)) w_lv_nxt = 1'b0;

        if (w_trs_valid) begin
            w_prev_v_nxt = w_v;
            if (w_sync_now) w_synced_nxt = 1'b1;
            if (w_v) begin
                w_armed_nxt  = 1'b1;
                w_frame_nxt  = 1'b0;
                w_active_nxt = 1'b0;
                w_lv_nxt     = 1'b0;
            end else begin
                if (w_start) begin
                    w_frame_nxt = 1'b1;
                    w_armed_nxt = 1'b0;
                    w_field_nxt = w_f;
                    w_row_nxt   = '0;
                end
                if (w_h) begin
                    // EAV: close the line and move to the next row
                    if (r_frame && (r_row != '1)) w_row_nxt = r_row + 1'b1;
                    w_active_nxt = 1'b0;
                    w_lv_nxt     = 1'b0;
                end else if (r_frame || w_start) begin
                    w_active_nxt = (w_row_base < c_ROW_LIM);
                    w_phase_nxt  = 1'b0;
                    w_lx_nxt     = '0;
                end
            end
        end else if (bt_ce && !w_trs_byte && r_active) begin
            w_phase_nxt = !r_phase;
            if (r_phase) begin
                if ((r_lx >= c_LX_LO) && (r_lx < c_LX_HI)) begin
                    w_dv_nxt   = 1'b1;
                    w_dout_nxt = bt_data;
                    w_addr_nxt = {r_row, r_field, r_lx - c_LX_LO};
                    w_lv_nxt   = 1'b1;
                end
                if (r_lx != '1) w_lx_nxt = r_lx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_synced <= 1'b0;
            r_prev_v <= 1'b0;
            r_armed  <= 1'b0;
            r_field  <= 1'b0;
            r_row    <= '0;
            r_frame  <= 1'b0;
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_lx     <= '0;
            r_lv     <= 1'b0;
            r_dv     <= 1'b0;
            r_dout   <= '0;
            r_addr   <= '0;
        end else begin
            r_synced <= w_synced_nxt;
            r_prev_v <= w_prev_v_nxt;
            r_armed  <= w_armed_nxt;
            r_field  <= w_field_nxt;
            r_row    <= w_row_nxt;
            r_frame  <= w_frame_nxt;
            r_active <= w_active_nxt;
            r_phase  <= w_phase_nxt;
            r_lx     <= w_lx_nxt;
            r_lv     <= w_lv_nxt;
            r_dv     <= w_dv_nxt;
            r_dout   <= w_dout_nxt;
            r_addr   <= w_addr_nxt;
        end
    end

    assign video_frame_valid = r_frame;
    assign video_line_valid  = r_lv;
    assign video_data_valid  = r_dv;
    assign video_data_out    = r_dout;
    assign video_address     = r_addr;

endmodule
`default_nettype wire
